// File: rtl/dispense_cmd_initiator.sv
// Host-side sequencer for the GPIO dispense protocol: drives motor-state, amount and
// candyflag to the dispenser, tracks its handshake line and reports a status per request.
module dispense_cmd_initiator #(
  parameter int SETUP_CYCLES   = 1_100_000,
  parameter int HOLD_CYCLES    = 2_080_000,
  parameter int TIMEOUT_CYCLES = 48_000_000,
  parameter int CNT_W          = 26
) (
  input  logic       clk,
  input  logic       rst,
  // Request port: a request transfers on a clock edge where req_valid and req_ready are both 1.
  // req_ready is 1 only while idle; the request fields are sampled on that same edge.
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_state,
  input  logic [1:0] req_amount,
  input  logic       req_dispense,
  input  logic       handshake_i,
  output logic [2:0] state_o,
  output logic [1:0] amount_o,
  output logic       candyflag_o,
  output logic       done,
  output logic [1:0] status,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVE    = 3'd1,
    S_SETUP   = 3'd2,
    S_ASSERT  = 3'd3,
    S_RELEASE = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_STALE   = 2'b10;
  localparam logic [1:0] ST_BAD_AMT = 2'b11;

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             hs_meta, hs_s;
  logic             accept;
  logic [2:0]       state_n;
  logic [1:0]       amount_n;
  logic             flag_n;
  logic [1:0]       status_n;

  assign accept    = req_valid & req_ready;
  assign fsm_state = state;

  // The handshake comes from another clock domain; every decision uses the resynchronised copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_meta <= 1'b0;
      hs_s    <= 1'b0;
    end else begin
      hs_meta <= handshake_i;
      hs_s    <= hs_meta;
    end
  end

  always_comb begin
    next_state = state;
    state_n    = state_o;
    amount_n   = amount_o;
    flag_n     = candyflag_o;
    status_n   = status;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (!req_dispense) begin
            state_n    = req_state;
            next_state = S_MOVE;
          end else if (req_amount == 2'b11) begin
            status_n   = ST_BAD_AMT;
            next_state = S_FIN;
          end else begin
            state_n    = 3'b000;
            amount_n   = req_amount;
            next_state = S_SETUP;
          end
        end
      end
      S_MOVE: begin
        if (cnt == HOLD_LAST) begin
          state_n    = 3'b000;
          status_n   = ST_OK;
          next_state = S_FIN;
        end
      end
      S_SETUP: begin
        flag_n = 1'b0;
        if (cnt == SETUP_LAST) begin
          // A handshake already high here belongs to some earlier exchange, so never strobe.
          if (hs_s) begin
            status_n   = ST_STALE;
            amount_n   = 2'b00;
            next_state = S_FIN;
          end else begin
            flag_n     = 1'b1;
            next_state = S_ASSERT;
          end
        end
      end
      S_ASSERT: begin
        if (hs_s) begin
          flag_n     = 1'b0;
          next_state = S_RELEASE;
        end else if (cnt == TIMEOUT_LAST) begin
          flag_n     = 1'b0;
          amount_n   = 2'b00;
          status_n   = ST_TIMEOUT;
          next_state = S_FIN;
        end
      end
      S_RELEASE: begin
        if (!hs_s) begin
          amount_n   = 2'b00;
          status_n   = ST_OK;
          next_state = S_FIN;
        end else if (cnt == TIMEOUT_LAST) begin
          amount_n   = 2'b00;
          status_n   = ST_TIMEOUT;
          next_state = S_FIN;
        end
      end
      S_FIN: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Registered outputs; done and req_ready are decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      state_o     <= 3'b000;
      amount_o    <= 2'b00;
      candyflag_o <= 1'b0;
      done        <= 1'b0;
      status      <= ST_OK;
      req_ready   <= 1'b0;
    end else begin
      state       <= next_state;
      state_o     <= state_n;
      amount_o    <= amount_n;
      candyflag_o <= flag_n;
      status      <= status_n;
      done        <= (next_state == S_FIN);
      req_ready   <= (next_state == S_IDLE);
      if (next_state != state) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dispense_cmd_initiator.sv
// Directed bench for dispense_cmd_initiator with shortened timing (SETUP=8, HOLD=5, TIMEOUT=20).
module tb_dispense_cmd_initiator;

  localparam int SETUP_CYCLES   = 8;
  localparam int HOLD_CYCLES    = 5;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int CNT_W          = 8;

  localparam logic [2:0] FSM_IDLE    = 3'd0;
  localparam logic [2:0] FSM_MOVE    = 3'd1;
  localparam logic [2:0] FSM_SETUP   = 3'd2;
  localparam logic [2:0] FSM_ASSERT  = 3'd3;
  localparam logic [2:0] FSM_RELEASE = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_state;
  logic [1:0] req_amount;
  logic       req_dispense;
  logic       handshake_i;
  logic [2:0] state_o;
  logic [1:0] amount_o;
  logic       candyflag_o;
  logic       done;
  logic [1:0] status;
  logic [2:0] fsm_state;

  int n_pass = 0;
  int n_total = 0;

  dispense_cmd_initiator #(
    .SETUP_CYCLES  (SETUP_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_state   (req_state),
    .req_amount  (req_amount),
    .req_dispense(req_dispense),
    .handshake_i (handshake_i),
    .state_o     (state_o),
    .amount_o    (amount_o),
    .candyflag_o (candyflag_o),
    .done        (done),
    .status      (status),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic disp, input logic [2:0] st, input logic [1:0] amt);
    req_valid    = 1'b1;
    req_dispense = disp;
    req_state    = st;
    req_amount   = amt;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_state = 3'b000; req_amount = 2'b00;
    req_dispense = 1'b0; handshake_i = 1'b0;
    tick(3);
    chk("rst_ready", req_ready, 0);
    chk("rst_state", state_o, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    rst = 1'b0;
    tick(1);
    chk("ready_after_rst", req_ready, 1);

    // 1: dispense amount=01, responder raises handshake 3 cycles after candyflag
    request(1'b1, 3'b101, 2'b01);
    tick(1);
    req_valid = 1'b0;
    chk("t1_accept_ready", req_ready, 0);
    chk("t1_amount_setup", amount_o, 2'b01);
    chk("t1_state_zero", state_o, 0);
    tick(7);
    chk("t1_flag_pre", candyflag_o, 0);
    tick(1);
    chk("t1_flag_rise", candyflag_o, 1);
    chk("t1_amount_flag", amount_o, 2'b01);
    chk("t1_fsm_assert", fsm_state, FSM_ASSERT);
    tick(3);
    handshake_i = 1'b1;
    tick(2);
    chk("t1_flag_sync_lat", candyflag_o, 1);
    tick(1);
    chk("t1_flag_drop", candyflag_o, 0);
    chk("t1_amount_release", amount_o, 2'b01);
    chk("t1_fsm_release", fsm_state, FSM_RELEASE);
    handshake_i = 1'b0;
    tick(2);
    chk("t1_done_early", done, 0);
    tick(1);
    chk("t1_done", done, 1);
    chk("t1_status", status, 2'b00);
    chk("t1_amount_clear", amount_o, 0);
    tick(1);
    chk("t1_done_once", done, 0);
    chk("t1_ready", req_ready, 1);

    // 2: motion request state=010
    request(1'b0, 3'b010, 2'b00);
    tick(1);
    req_valid = 1'b0;
    chk("t2_state_drive", state_o, 3'b010);
    chk("t2_fsm_move", fsm_state, FSM_MOVE);
    tick(4);
    chk("t2_state_hold", state_o, 3'b010);
    chk("t2_done_early", done, 0);
    tick(1);
    chk("t2_state_clear", state_o, 0);
    chk("t2_done", done, 1);
    chk("t2_status", status, 2'b00);
    tick(1);
    chk("t2_ready", req_ready, 1);

    // 3: dispense amount=10, handshake never rises
    request(1'b1, 3'b000, 2'b10);
    tick(1);
    req_valid = 1'b0;
    tick(8);
    chk("t3_flag_rise", candyflag_o, 1);
    chk("t3_amount", amount_o, 2'b10);
    tick(19);
    chk("t3_flag_last", candyflag_o, 1);
    tick(1);
    chk("t3_flag_timeout", candyflag_o, 0);
    chk("t3_amount_clear", amount_o, 0);
    chk("t3_state_zero", state_o, 0);
    chk("t3_done", done, 1);
    chk("t3_status", status, 2'b01);
    tick(1);
    chk("t3_status_held", status, 2'b01);
    chk("t3_done_once", done, 0);

    // 4a: handshake already high before the request -> stale
    handshake_i = 1'b1;
    tick(2);
    request(1'b1, 3'b000, 2'b01);
    tick(1);
    req_valid = 1'b0;
    chk("t4_fsm_setup", fsm_state, FSM_SETUP);
    tick(7);
    chk("t4_flag_setup", candyflag_o, 0);
    tick(1);
    chk("t4_flag_never", candyflag_o, 0);
    chk("t4_done", done, 1);
    chk("t4_status", status, 2'b10);
    chk("t4_amount_clear", amount_o, 0);
    handshake_i = 1'b0;
    tick(1);
    chk("t4_ready", req_ready, 1);
    tick(2);

    // 4b: illegal amount
    request(1'b1, 3'b110, 2'b11);
    tick(1);
    req_valid = 1'b0;
    chk("t4b_done", done, 1);
    chk("t4b_status", status, 2'b11);
    chk("t4b_state", state_o, 0);
    chk("t4b_amount", amount_o, 0);
    chk("t4b_flag", candyflag_o, 0);
    tick(1);
    chk("t4b_ready", req_ready, 1);

    // 5: reset in the middle of ASSERT
    request(1'b1, 3'b000, 2'b10);
    tick(1);
    req_valid = 1'b0;
    tick(8);
    chk("t5_flag_rise", candyflag_o, 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("t5_flag", candyflag_o, 0);
    chk("t5_amount", amount_o, 0);
    chk("t5_done", done, 0);
    chk("t5_status", status, 0);
    chk("t5_ready", req_ready, 0);
    chk("t5_fsm", fsm_state, FSM_IDLE);
    rst = 1'b0;
    tick(1);
    chk("t5_ready_after", req_ready, 1);
    chk("t5_no_done", done, 0);
    tick(1);
    chk("t5_no_done_late", done, 0);

    // 6: req_valid held high across a motion transaction
    request(1'b0, 3'b011, 2'b00);
    tick(1);
    chk("t6_state1", state_o, 3'b011);
    chk("t6_ready_busy", req_ready, 0);
    tick(4);
    chk("t6_ignored", req_ready, 0);
    tick(1);
    chk("t6_done1", done, 1);
    chk("t6_ready_fin", req_ready, 0);
    tick(1);
    chk("t6_ready_idle", req_ready, 1);
    chk("t6_done1_once", done, 0);
    chk("t6_state_idle", state_o, 0);
    tick(1);
    req_valid = 1'b0;
    chk("t6_accept2", state_o, 3'b011);
    chk("t6_ready2", req_ready, 0);
    tick(5);
    chk("t6_done2", done, 1);
    chk("t6_status2", status, 2'b00);
    tick(1);
    chk("t6_final_ready", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
